// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 keypad column scanner with debounce, key decode and 4-digit shift-in entry register; define KEYPAD_REPEAT_EN for auto-repeat while held
module keypad_scan_entry #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_enable,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] DB_ACC = CW'(DEBOUNCE_TICKS - 2);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);
  // nibble (row*4 + col) holds the code printed on that key
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t state;
  logic [3:0] rows_m, rows_s, row_cap, code;
  logic [1:0] col_idx, row_idx;
  logic [CW-1:0] cnt;
  logic idle, match, fire_acc, fire_rep;
  assign cols = ~(4'b0001 << col_idx);
  // two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end
  // row match flags, lowest-row-wins decode and the acceptance strobe
  always_comb begin
    idle = rows_s == 4'hF;
    match = rows_s == row_cap;
    row_idx = !row_cap[0] ? 2'd0 : !row_cap[1] ? 2'd1 : !row_cap[2] ? 2'd2 : 2'd3;
    code = KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
    fire_acc = clk_enable && state == DEBOUNCE && match && cnt == DB_ACC;
  end
  // scan / debounce / hold sequencing, advancing only on scan ticks
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SCAN;
      col_idx <= 2'd0;
      row_cap <= 4'hF;
      cnt <= '0;
    end else if (clk_enable) begin
      case (state)
        SCAN:
          if (idle) col_idx <= col_idx + 2'd1;
          else begin
            row_cap <= rows_s;
            cnt <= '0;
            state <= DEBOUNCE;
          end
        DEBOUNCE:
          if (!match) begin
            state <= SCAN;
            col_idx <= col_idx + 2'd1;
          end else if (cnt == DB_ACC) begin
            state <= HELD;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!idle) cnt <= '0;
          else if (cnt == DB_LAST) begin
            state <= SCAN;
            col_idx <= col_idx + 2'd1;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        default: state <= SCAN;
      endcase
    end
  end
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(2 * REPEAT_TICKS);
  localparam logic [RW-1:0] RP_FIRST = RW'(2 * REPEAT_TICKS - 1);
  localparam logic [RW-1:0] RP_NEXT = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep_cnt;
  assign fire_rep = clk_enable && state == HELD && match && rep_cnt == RP_FIRST;
  // ticks since acceptance (or last repeat), restarted by release or a pattern change
  always_ff @(posedge clk) begin
    if (!reset_n || state != HELD) rep_cnt <= '0;
    else if (clk_enable) rep_cnt <= !match ? '0 : fire_rep ? RP_NEXT : rep_cnt + 1'b1;
  end
`else
  assign fire_rep = 1'b0;
`endif
  // accepted key: pulse, latch its code and apply it to the entry register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_valid <= 1'b0;
      key_code <= 4'h0;
      digit0 <= 4'h0;
      digit1 <= 4'h0;
      digit2 <= 4'h0;
      digit3 <= 4'h0;
    end else begin
      key_valid <= fire_acc || fire_rep;
      if (fire_acc || fire_rep) begin
        key_code <= code;
        if (code <= 4'd9) begin
          digit3 <= digit2;
          digit2 <= digit1;
          digit1 <= digit0;
          digit0 <= code;
        end else if (code == 4'hE) begin
          digit0 <= 4'h0;
          digit1 <= 4'h0;
          digit2 <= 4'h0;
          digit3 <= 4'h0;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_entry.sv
// tb_keypad_scan_entry: keypad presses against a press-level model of scanning, debounce and digit entry
module tb_keypad_scan_entry;
  localparam int RT = 3;
  logic clk = 1'b0, reset_n = 1'b0, clk_enable = 1'b0;
  logic [3:0] rows, cols, key_code, digit0, digit1, digit2, digit3;
  logic key_valid;
  logic kv_prev = 1'b0;
  logic [15:0] pressed = '0;
  int total = 0, bad = 0, pulses = 0, doubles = 0;
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] exp_cols [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [3:0] md [4];

  keypad_scan_entry #(.DEBOUNCE_TICKS(4), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_code(key_code),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
  end

  always @(negedge clk) begin
    if (key_valid) pulses++;
    if (key_valid && kv_prev) doubles++;
    kv_prev = key_valid;
  end

  task automatic tick();
    repeat ($urandom_range(3, 6)) @(negedge clk);
    clk_enable = 1'b1;
    @(negedge clk);
    clk_enable = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    md = '{default: 4'h0};
  endtask

  task automatic model_apply(input logic [3:0] c);
    if (c <= 4'd9) begin
      md[3] = md[2];
      md[2] = md[1];
      md[1] = md[0];
      md[0] = c;
    end else if (c == 4'hE) md = '{default: 4'h0};
  endtask

  task automatic press(input logic [15:0] m, input int extra, output int got);
    int p0, n;
    p0 = pulses;
    n = 0;
    pressed = m;
    while (pulses == p0 && n < 24) begin
      tick();
      n++;
    end
    repeat (extra) tick();
    pressed = '0;
    repeat (6) tick();
    got = pulses - p0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL reset_cols got=%b want=1110", cols); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv got=%b want=0", key_valid); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", key_code); end
    total++; if ({digit3, digit2, digit1, digit0} !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h want=0000", {digit3, digit2, digit1, digit0}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (cols !== exp_cols[i]) begin bad++; $display("FAIL scan_cols step=%0d got=%b want=%b", i, cols, exp_cols[i]); end
    end
    repeat (20) @(negedge clk);
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL freeze_cols got=%b want=1110", cols); end
  endtask

  task automatic test_single_press();
    int p0;
    do_reset();
    tick();
    p0 = pulses;
    pressed[5] = 1'b1;
    repeat (3) tick();
    total++; if (pulses !== p0) begin bad++; $display("FAIL early_pulse got=%0d want=%0d", pulses - p0, 0); end
    tick();
    model_apply(4'h5);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL accept_pulse got=%0d want=1", pulses - p0); end
    total++; if (key_code !== 4'h5) begin bad++; $display("FAIL accept_code got=%h want=5", key_code); end
    total++; if ({digit3, digit2, digit1, digit0} !== {md[3], md[2], md[1], md[0]}) begin bad++; $display("FAIL accept_digits got=%h want=0005", {digit3, digit2, digit1, digit0}); end
    repeat (2) tick();
    pressed[5] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (cols !== 4'b1101) begin bad++; $display("FAIL held_cols rel=%0d got=%b want=1101", i, cols); end
    end
    tick();
    total++; if (cols !== 4'b1011) begin bad++; $display("FAIL release_cols got=%b want=1011", cols); end
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL single_pulse got=%0d want=1", pulses - p0); end
  endtask

  task automatic test_bounce();
    int p0, n;
    do_reset();
    tick();
    p0 = pulses;
    pressed[5] = 1'b1;
    repeat (2) tick();
    pressed[5] = 1'b0;
    tick();
    total++; if (pulses !== p0) begin bad++; $display("FAIL bounce_early got=%0d want=0", pulses - p0); end
    pressed[5] = 1'b1;
    n = 0;
    while (pulses == p0 && n < 24) begin
      tick();
      n++;
    end
    total++; if (n !== 7) begin bad++; $display("FAIL bounce_latency got=%0d want=7 ticks", n); end
    pressed[5] = 1'b0;
    repeat (6) tick();
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", pulses - p0); end
    do_reset();
    tick();
    p0 = pulses;
    pressed[5] = 1'b1;
    repeat (2) tick();
    pressed[5] = 1'b0;
    repeat (12) tick();
    total++; if (pulses !== p0) begin bad++; $display("FAIL short_press got=%0d want=0", pulses - p0); end
  endtask

  task automatic test_entry();
    int got;
    int seq [7] = '{0, 1, 2, 13, 12, 8, 3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      press(16'(1) << seq[i], $urandom_range(0, 2), got);
      model_apply(keymap[seq[i]]);
      total++; if (got !== 1) begin bad++; $display("FAIL entry_pulses key=%h got=%0d want=1", keymap[seq[i]], got); end
      total++; if (key_code !== keymap[seq[i]]) begin bad++; $display("FAIL entry_code got=%h want=%h", key_code, keymap[seq[i]]); end
      total++; if ({digit3, digit2, digit1, digit0} !== {md[3], md[2], md[1], md[0]}) begin bad++; $display("FAIL entry_digits key=%h got=%h want=%h", keymap[seq[i]], {digit3, digit2, digit1, digit0}, {md[3], md[2], md[1], md[0]}); end
      if (i == 3) begin
        total++; if ({digit3, digit2, digit1, digit0} !== 16'h1230) begin bad++; $display("FAIL entry_1230 got=%h want=1230", {digit3, digit2, digit1, digit0}); end
      end
    end
  endtask

  task automatic test_multirow();
    int got, p0;
    do_reset();
    press(16'h0110, 0, got);
    total++; if (got !== 1) begin bad++; $display("FAIL multirow_pulses got=%0d want=1", got); end
    total++; if (key_code !== 4'h4) begin bad++; $display("FAIL multirow_code got=%h want=4", key_code); end
    do_reset();
    p0 = pulses;
    pressed[0] = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL abort_cols got=%b want=1110", cols); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL abort_kv got=%b want=0", key_valid); end
    pressed[0] = 1'b0;
    repeat (8) tick();
    total++; if (pulses !== p0) begin bad++; $display("FAIL abort_pulse got=%0d want=0", pulses - p0); end
  endtask

  task automatic test_repeat();
    int p, n;
    logic obs, exp;
    do_reset();
    p = pulses;
    n = 0;
    pressed[10] = 1'b1;
    while (pulses == p && n < 24) begin
      tick();
      n++;
    end
    total++; if (pulses !== p + 1) begin bad++; $display("FAIL repeat_first got=%0d want=1", pulses - p); end
    for (int rel = 1; rel < 20; rel++) begin
      p = pulses;
      tick();
      obs = pulses != p;
`ifdef KEYPAD_REPEAT_EN
      exp = rel >= 2 * RT && (rel - 2 * RT) % RT == 0;
`else
      exp = 1'b0;
`endif
      total++; if (obs !== exp) begin bad++; $display("FAIL repeat_tick rel=%0d got=%b want=%b", rel, obs, exp); end
    end
    pressed[10] = 1'b0;
    repeat (6) tick();
    total++; if (digit0 !== 4'h9) begin bad++; $display("FAIL repeat_digit got=%h want=9", digit0); end
  endtask

  task automatic test_random();
    int got, k;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 15);
      press(16'(1) << k, $urandom_range(0, 4), got);
      model_apply(keymap[k]);
      total++; if (got !== 1) begin bad++; $display("FAIL rand_pulses key=%h got=%0d want=1", keymap[k], got); end
      total++; if (key_code !== keymap[k]) begin bad++; $display("FAIL rand_code got=%h want=%h", key_code, keymap[k]); end
      total++; if ({digit3, digit2, digit1, digit0} !== {md[3], md[2], md[1], md[0]}) begin bad++; $display("FAIL rand_digits got=%h want=%h", {digit3, digit2, digit1, digit0}, {md[3], md[2], md[1], md[0]}); end
    end
    total++; if (doubles !== 0) begin bad++; $display("FAIL back_to_back got=%0d want=0", doubles); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_entry();
    test_multirow();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
